// File: rtl/datachk_pkg.sv
// Shared definitions for the datachk AXI-Stream checker: FSM state encodings
// (also decoded by datagen debug logic) and capture-buffer geometry.
package datachk_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int BUF_AW = 8;
  localparam int BUF_DW = 8;

endpackage

// File: rtl/dp_ram_256x8.sv
// 256x8 simple dual-port RAM: one synchronous write port, one registered read
// port. A same-edge read of the written address returns the old contents.
module dp_ram_256x8
  import datachk_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              we,
  input  logic [BUF_AW-1:0] wr_addr,
  input  logic [BUF_DW-1:0] wr_data,
  input  logic [BUF_AW-1:0] rd_addr,
  output logic [BUF_DW-1:0] rd_data
);

  logic [BUF_DW-1:0] mem [2**BUF_AW];
  logic [BUF_DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/datachk.sv
// AXI-Stream byte-frame sink: captures each frame into a 256-entry buffer,
// checks the payload increments by STEP and the length matches frame_size.
module datachk
  import datachk_pkg::*;
#(
  parameter int STEP  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [7:0]       frame_size,
  input  logic             clr,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic [7:0]       s_axis_tdata,
  input  logic [7:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             err_data,
  output logic             err_len,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       debug_state
);

  localparam logic [7:0] STEP_B = 8'(STEP);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       wr_ptr_q, wr_ptr_d;
  logic [7:0]       expected_q, expected_d;
  logic             done_q, done_d;
  logic             err_data_q, err_data_d;
  logic             err_len_q, err_len_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       beat;
  logic       finish;
  logic       buf_we;
  logic [7:0] fs_m1;

  assign fs_m1         = frame_size - 8'd1;
  assign s_axis_tready = (state_q == S_RECV) || (state_q == S_DRAIN);
  assign beat          = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    expected_d  = expected_q;
    done_d      = done_q;
    err_data_d  = err_data_q;
    err_len_d   = err_len_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    finish      = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        wr_ptr_d   = '0;
        done_d     = 1'b0;
        err_data_d = 1'b0;
        err_len_d  = 1'b0;
        if (en) begin
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        if (beat) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 8'd1;
          // First beat seeds the sequence; later beats free-run from it.
          if (wr_ptr_q == 8'd0) begin
            expected_d = s_axis_tdata + STEP_B;
          end else begin
            if (s_axis_tdata != expected_q) begin
              err_data_d = 1'b1;
            end
            expected_d = expected_q + STEP_B;
          end

          if (s_axis_tlast) begin
            if (wr_ptr_q != fs_m1) begin
              err_len_d = 1'b1;
            end
            state_d = S_DONE;
            finish  = 1'b1;
          end else if (wr_ptr_q == fs_m1) begin
            err_len_d = 1'b1;
            state_d   = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (beat && s_axis_tlast) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end
      end

      S_DONE: begin
        if (clr) begin
          done_d     = 1'b0;
          err_data_d = 1'b0;
          err_len_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Counters see the flags as they will be after this edge.
    if (finish) begin
      done_d      = 1'b1;
      frame_cnt_d = sat_inc(frame_cnt_q);
      if (err_data_d || err_len_d) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      expected_q  <= '0;
      done_q      <= 1'b0;
      err_data_q  <= 1'b0;
      err_len_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      expected_q  <= expected_d;
      done_q      <= done_d;
      err_data_q  <= err_data_d;
      err_len_q   <= err_len_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  dp_ram_256x8 u_buf (
    .clk     (clk),
    .nrst    (nrst),
    .we      (buf_we),
    .wr_addr (wr_ptr_q),
    .wr_data (s_axis_tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign done        = done_q;
  assign err_data    = err_data_q;
  assign err_len     = err_len_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign debug_state = state_q;

endmodule
